// File: rtl/seq_rec_trig_core_if.sv
// Byte-wide register/memory bus between a host and seq_rec_trig_core.
//   BUS_ADD      : byte address
//   BUS_DATA_IN  : write data
//   BUS_DATA_OUT : read data, registered; valid the cycle after BUS_RD
//   BUS_RD       : read strobe
//   BUS_WR       : write strobe
interface seq_rec_trig_core_if #(
  parameter int ABUSWIDTH = 16
) ();
  logic [ABUSWIDTH-1:0] BUS_ADD;
  logic [7:0]           BUS_DATA_IN;
  logic [7:0]           BUS_DATA_OUT;
  logic                 BUS_RD;
  logic                 BUS_WR;

  modport master (
    output BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR,
    input  BUS_DATA_OUT
  );

  modport slave (
    input  BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR,
    output BUS_DATA_OUT
  );
endinterface

// File: rtl/seq_rec_trig_core.sv
// Sequence recorder with pre/post trigger capture into a circular sample
// memory, configured and read back over a byte-wide register bus.
//
// Ports
//   BUS_CLK       : the only clock, rising edge
//   BUS_RST       : synchronous active-high reset
//   bus           : register/memory bus (slave side)
//   SEQ_IN        : sample data, IN_BITS wide
//   SEQ_EXT_START : external trigger, rising edge detected
//   BUSY          : capture in progress
//   TRIGGERED     : trigger seen since the last START or reset
//
// Register map: 0 soft reset / VERSION, 1 START / status, 2 CONF,
// 3-4 SIZE, 5-6 PRE_TRIG, 7-8 TRIG_ADDR (ro), 9-12 TRIG_MASK,
// 13-16 TRIG_VALUE, 17 DIV, 32.. sample memory (ro, LE bytes per sample).
//
// State | meaning
// IDLE  | no capture; waits for START
// PRE   | recording the EP pre-trigger samples
// WAIT  | recording circularly, evaluating the trigger on each strobe
// POST  | recording the remaining ES-EP samples after the trigger
module seq_rec_trig_core #(
  parameter int ABUSWIDTH = 16,
  parameter int MEM_BYTES = 8192,
  parameter int IN_BITS   = 8,
  parameter int VERSION   = 1
) (
  input  logic               BUS_CLK,
  input  logic               BUS_RST,
  seq_rec_trig_core_if.slave bus,
  input  logic [IN_BITS-1:0] SEQ_IN,
  input  logic               SEQ_EXT_START,
  output logic               BUSY,
  output logic               TRIGGERED
);

  localparam int BYTES    = IN_BITS / 8;
  localparam int DEPTH    = MEM_BYTES / BYTES;
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MEM_BASE = 32;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_WAIT, S_POST} state_t;

  state_t state_q, state_d;

  logic [7:0]  conf_q;
  logic [15:0] size_q;
  logic [15:0] pre_q;
  logic [31:0] mask_q;
  logic [31:0] value_q;
  logic [7:0]  div_q;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] trig_addr_q, trig_addr_d;
  logic [7:0]    div_cnt_q, div_cnt_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   post_len_q, post_len_d;
  logic          done_q, done_d;
  logic          trig_q, trig_d;
  logic          ext_prev_q;
  logic [7:0]    rdata_q;

  logic [IN_BITS-1:0] mem_q [DEPTH];

  logic soft_rst, rst, start, busy, strobe, mem_we;
  logic size_full;
  logic [AW:0] es, ep;
  logic ext_hit, pat_hit, trig_hit;

  assign soft_rst = bus.BUS_WR && (bus.BUS_ADD == ABUSWIDTH'(0));
  assign rst      = BUS_RST || soft_rst;
  assign start    = bus.BUS_WR && (bus.BUS_ADD == ABUSWIDTH'(1)) && !rst;

  assign busy      = (state_q != S_IDLE);
  assign strobe    = busy && (div_cnt_q == 8'd0);
  assign BUSY      = busy;
  assign TRIGGERED = trig_q;

  // SIZE is bounded by the memory depth, so ES always fits in AW+1 bits.
  assign size_full = (size_q == 16'd0) || (32'(size_q) > 32'(DEPTH));
  assign es        = size_full ? DEPTH_W : (AW+1)'(size_q);
  assign ep        = (32'(pre_q) < 32'(es)) ? (AW+1)'(pre_q) : es - CNT_ONE;

  assign ext_hit  = conf_q[0] && SEQ_EXT_START && !ext_prev_q;
  assign pat_hit  = conf_q[1] &&
                    ((SEQ_IN & mask_q[IN_BITS-1:0]) == (value_q[IN_BITS-1:0] & mask_q[IN_BITS-1:0]));
  assign trig_hit = ext_hit || pat_hit || (conf_q[1:0] == 2'b00);

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    div_cnt_d   = div_cnt_q;
    cnt_d       = cnt_q;
    post_len_d  = post_len_q;
    trig_addr_d = trig_addr_q;
    done_d      = done_q;
    trig_d      = trig_q;
    mem_we      = 1'b0;

    if (busy) div_cnt_d = strobe ? div_q : div_cnt_q - 8'd1;

    if (strobe) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + AW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d     = 1'b0;
          trig_d     = 1'b0;
          wptr_d     = '0;
          div_cnt_d  = 8'd0;
          cnt_d      = ep;
          // ES and EP are frozen here so bus writes during a capture
          // cannot change its length.
          post_len_d = es - ep;
          state_d    = (ep == '0) ? S_WAIT : S_PRE;
        end
      end
      S_PRE: begin
        if (strobe) begin
          if (cnt_q == CNT_ONE) state_d = S_WAIT;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_WAIT: begin
        if (strobe && trig_hit) begin
          trig_d      = 1'b1;
          trig_addr_d = wptr_q;
          // The trigger sample is the first of the post samples.
          if (post_len_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d   = post_len_q - CNT_ONE;
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        if (strobe) begin
          if (cnt_q == CNT_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      trig_addr_q <= '0;
      div_cnt_q   <= 8'd0;
      cnt_q       <= '0;
      post_len_q  <= '0;
      done_q      <= 1'b0;
      trig_q      <= 1'b0;
      ext_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      trig_addr_q <= trig_addr_d;
      div_cnt_q   <= div_cnt_d;
      cnt_q       <= cnt_d;
      post_len_q  <= post_len_d;
      done_q      <= done_d;
      trig_q      <= trig_d;
      ext_prev_q  <= SEQ_EXT_START;
    end
  end

  // Memory is never cleared; a reset only stops further writes.
  always_ff @(posedge BUS_CLK) begin
    if (mem_we && !rst) mem_q[wptr_q] <= SEQ_IN;
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      conf_q  <= 8'd0;
      size_q  <= 16'd0;
      pre_q   <= 16'd0;
      mask_q  <= 32'd0;
      value_q <= 32'd0;
      div_q   <= 8'd0;
    end else if (bus.BUS_WR) begin
      case (bus.BUS_ADD)
        ABUSWIDTH'(2):  conf_q         <= bus.BUS_DATA_IN;
        ABUSWIDTH'(3):  size_q[7:0]    <= bus.BUS_DATA_IN;
        ABUSWIDTH'(4):  size_q[15:8]   <= bus.BUS_DATA_IN;
        ABUSWIDTH'(5):  pre_q[7:0]     <= bus.BUS_DATA_IN;
        ABUSWIDTH'(6):  pre_q[15:8]    <= bus.BUS_DATA_IN;
        ABUSWIDTH'(9):  mask_q[7:0]    <= bus.BUS_DATA_IN;
        ABUSWIDTH'(10): mask_q[15:8]   <= bus.BUS_DATA_IN;
        ABUSWIDTH'(11): mask_q[23:16]  <= bus.BUS_DATA_IN;
        ABUSWIDTH'(12): mask_q[31:24]  <= bus.BUS_DATA_IN;
        ABUSWIDTH'(13): value_q[7:0]   <= bus.BUS_DATA_IN;
        ABUSWIDTH'(14): value_q[15:8]  <= bus.BUS_DATA_IN;
        ABUSWIDTH'(15): value_q[23:16] <= bus.BUS_DATA_IN;
        ABUSWIDTH'(16): value_q[31:24] <= bus.BUS_DATA_IN;
        ABUSWIDTH'(17): div_q          <= bus.BUS_DATA_IN;
        default: ;
      endcase
    end
  end

  // Memory window: byte offset splits into sample index and byte lane.
  logic [ABUSWIDTH-1:0] moff;
  logic [AW-1:0]        midx;
  logic [1:0]           mbyte;
  logic [IN_BITS-1:0]   mword;
  logic [7:0]           mem_byte;
  logic                 in_mem;
  logic [15:0]          taddr16;
  logic [7:0]           rd_byte;

  assign moff     = bus.BUS_ADD - ABUSWIDTH'(MEM_BASE);
  assign midx     = AW'(moff / ABUSWIDTH'(BYTES));
  assign mbyte    = 2'(moff % ABUSWIDTH'(BYTES));
  assign mword    = mem_q[midx];
  assign mem_byte = 8'(mword >> {mbyte, 3'b000});
  assign in_mem   = (bus.BUS_ADD >= ABUSWIDTH'(MEM_BASE)) && (32'(moff) < 32'(MEM_BYTES));
  assign taddr16  = 16'(trig_addr_q);

  always_comb begin
    rd_byte = 8'h00;
    if (in_mem) begin
      rd_byte = mem_byte;
    end else begin
      case (bus.BUS_ADD)
        ABUSWIDTH'(0):  rd_byte = 8'(VERSION);
        ABUSWIDTH'(1):  rd_byte = {5'b00000, trig_q, busy, done_q};
        ABUSWIDTH'(2):  rd_byte = conf_q;
        ABUSWIDTH'(3):  rd_byte = size_q[7:0];
        ABUSWIDTH'(4):  rd_byte = size_q[15:8];
        ABUSWIDTH'(5):  rd_byte = pre_q[7:0];
        ABUSWIDTH'(6):  rd_byte = pre_q[15:8];
        ABUSWIDTH'(7):  rd_byte = taddr16[7:0];
        ABUSWIDTH'(8):  rd_byte = taddr16[15:8];
        ABUSWIDTH'(9):  rd_byte = mask_q[7:0];
        ABUSWIDTH'(10): rd_byte = mask_q[15:8];
        ABUSWIDTH'(11): rd_byte = mask_q[23:16];
        ABUSWIDTH'(12): rd_byte = mask_q[31:24];
        ABUSWIDTH'(13): rd_byte = value_q[7:0];
        ABUSWIDTH'(14): rd_byte = value_q[15:8];
        ABUSWIDTH'(15): rd_byte = value_q[23:16];
        ABUSWIDTH'(16): rd_byte = value_q[31:24];
        ABUSWIDTH'(17): rd_byte = div_q;
        default:        rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst)              rdata_q <= 8'h00;
    else if (bus.BUS_RD)  rdata_q <= rd_byte;
    else                  rdata_q <= 8'h00;
  end

  assign bus.BUS_DATA_OUT = rdata_q;

endmodule

// File: doc/seq_rec_trig_core.md
SEQ_REC_TRIG_CORE -- requirements
Module: seq_rec_trig_core

Interface
REQ-001 SHALL have parameter ABUSWIDTH, default 16, bus address width.
REQ-002 SHALL have parameter MEM_BYTES, default 8192, sample memory size in bytes; DEPTH = MEM_BYTES/(IN_BITS/8) samples, power of two.
REQ-003 SHALL have parameter IN_BITS, default 8, sample width; legal values 8, 16, 24, 32.
REQ-004 SHALL have parameter VERSION, default 1, value returned on read of address 0.
REQ-005 SHALL have port BUS_CLK, input, 1 bit, the only clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port BUS_RST, input, 1 bit, reset, synchronous and active-high.
REQ-007 SHALL have ports BUS_ADD (input, ABUSWIDTH), BUS_DATA_IN (input, 8), BUS_DATA_OUT (output, 8), BUS_RD (input, 1) and BUS_WR (input, 1), forming a byte-wide register/memory bus.
REQ-008 SHALL have port SEQ_IN, input, IN_BITS bits, recorded data, synchronous to BUS_CLK.
REQ-009 SHALL have port SEQ_EXT_START, input, 1 bit, external trigger, synchronous to BUS_CLK.
REQ-010 SHALL have ports BUSY (output, 1; high when state is not IDLE) and TRIGGERED (output, 1; high from trigger until the next START or reset).

Function
REQ-011 SHALL decode this register map:
- 0: write = soft reset; read = VERSION.
- 1: write = START; read = status {5'b0, TRIGGERED, BUSY, DONE}.
- 2: CONF, r/w; bit0 EN_EXT_START, bit1 EN_PATTERN.
- 3-4: SIZE, 16 bits, LE, r/w.
- 5-6: PRE_TRIG, 16 bits, LE, r/w.
- 7-8: TRIG_ADDR, read-only.
- 9-12: TRIG_MASK, 32 bits, LE, r/w.
- 13-16: TRIG_VALUE, 32 bits, LE, r/w.
- 17: DIV, r/w.
- 32 and above: sample memory, read-only, LE bytes per sample.
REQ-012 SHALL register read data: BUS_DATA_OUT is valid the cycle after BUS_RD is high; unmapped addresses return 0x00.
REQ-013 SHALL ignore writes to read-only and memory addresses.
REQ-014 SHALL use effective size ES = DEPTH when SIZE is 0 or greater than DEPTH; otherwise ES = SIZE.
REQ-015 SHALL use effective pre-trigger EP = min(PRE_TRIG, ES-1).
REQ-016 SHALL generate the sample strobe once every DIV+1 cycles while BUSY, with the first strobe in the cycle after START enters PRE.
REQ-017 SHALL, on each strobe, write SEQ_IN to mem[wptr], then set wptr = (wptr+1) mod DEPTH; wptr is cleared to 0 on START.
REQ-018 SHALL implement the state machine IDLE, PRE, WAIT, POST, with these transitions:
- IDLE -> PRE on START.
- PRE -> WAIT after EP strobes; PRE is skipped (IDLE -> WAIT) when EP = 0.
- WAIT -> POST on trigger.
- POST -> IDLE after ES-EP strobes in total, counting the trigger sample.
- On POST -> IDLE, DONE is set.
REQ-019 SHALL evaluate the trigger in WAIT, only on strobe cycles:
- ext = EN_EXT_START and SEQ_EXT_START high while the previous-cycle SEQ_EXT_START was low (rising edge).
- pat = EN_PATTERN and (SEQ_IN & MASK) == (VALUE & MASK), with MASK and VALUE truncated to IN_BITS.
- trigger = ext or pat; when both enables are 0, trigger = 1 on the first WAIT strobe.
REQ-020 SHALL, on trigger, latch TRIG_ADDR to the wptr of the trigger sample (the sample written in the same strobe) and set TRIGGERED.
REQ-021 SHALL let WAIT write circularly until trigger; the oldest valid sample is at (TRIG_ADDR-EP) mod DEPTH.
REQ-022 SHALL ignore trigger conditions during PRE and POST; an ext rising edge that occurs on a non-strobe cycle is lost.
REQ-023 SHALL ignore START while BUSY; START in IDLE clears DONE and TRIGGERED.
REQ-024 SHALL give soft reset precedence over a same-cycle START.
REQ-025 SHALL serve memory reads in any state; reading the address currently being written returns the old or the new sample, either being acceptable.

Reset
REQ-026 SHALL, on BUS_RST or soft reset (next cycle), apply:
- state = IDLE; wptr, counters, DONE, TRIGGERED, BUSY = 0.
- CONF, SIZE, PRE_TRIG, TRIG_MASK, TRIG_VALUE, DIV, TRIG_ADDR = 0.
- BUS_DATA_OUT = 0x00.
- Memory contents are not cleared.
REQ-027 SHALL, when reset occurs mid-operation, abort the capture immediately without setting DONE and without further memory writes.

Verification
REQ-028 SHALL cover: IN_BITS=8, SIZE=16, PRE_TRIG=0, CONF=0, DIV=0, SEQ_IN = cycle counter, START -> BUSY for 16 cycles, DONE=1, TRIG_ADDR=0, mem[0..15] = consecutive values.
REQ-029 SHALL cover: SIZE=16, PRE_TRIG=4, EN_PATTERN, MASK=0xFF, VALUE=0x40, counter input from 0x00 -> TRIG_ADDR=0x40 mod DEPTH, the 4 samples before it read 0x3C..0x3F, and the 12 samples from it read 0x40..0x4B.
REQ-030 SHALL cover: EN_EXT_START, pulse SEQ_EXT_START during PRE (ignored), then again in WAIT -> TRIGGERED rises only on the second pulse, and TRIG_ADDR matches the sample of the second pulse.
REQ-031 SHALL cover: DIV=3, SIZE=4, CONF=0 -> memory writes exactly every 4th cycle, and DONE after 16 cycles.
REQ-032 SHALL cover: BUS_RST (or a write to address 0) asserted in WAIT -> BUSY=0 next cycle, DONE=0, status reads 0x00, and a following START works normally.
REQ-033 SHALL cover: SIZE=0, PRE_TRIG=0xFFFF -> ES=DEPTH, EP=DEPTH-1; START while BUSY has no effect.
